// File: rtl/sram_arb_pkg.sv
// Shared FSM state encodings and winner constants for the two-port SRAM arbiter.
package sram_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ISSUE      = 3'd1,
        ST_WAIT_START = 3'd2,
        ST_WAIT_DONE  = 3'd3,
        ST_DONE       = 3'd4
    } state_t;

    localparam logic WIN_P0 = 1'b0;
    localparam logic WIN_P1 = 1'b1;

endpackage

// File: rtl/sram_arb_select.sv
// Combinational winner selection: a tie goes to the port that was not granted last.
module sram_arb_select
    import sram_arb_pkg::*;
(
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last,
    output logic o_winner,
    output logic o_valid
);

    always_comb begin
        o_valid  = i_req0 | i_req1;
        o_winner = WIN_P0;
        if (i_req0 && i_req1) begin
            o_winner = (i_last == WIN_P0) ? WIN_P1 : WIN_P0;
        end else if (i_req1) begin
            o_winner = WIN_P1;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of a single-transaction SRAM controller.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; default build is fixed priority (p0 wins).
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p1_req,
    input  logic              p0_we,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p0_done,
    output logic              p1_done,
    output logic [DATA_W-1:0] p0_rdata,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              mem_wrEn,
    output logic              mem_rdEn,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writeData,
    input  logic [DATA_W-1:0] mem_readData,
    input  logic              mem_ready,
    output logic              busy,
    output logic              grant_id
);

    state_t r_state;
    logic   r_we;
    logic   w_last;
    logic   w_winner;
    logic   w_valid;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last;

    // Last-grant pointer starts at p1 so p0 takes the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= WIN_P1;
        end else if (r_state == ST_IDLE && mem_ready && w_valid) begin
            r_last <= w_winner;
        end
    end

    assign w_last = r_last;
`else
    // Constant "p1 granted last" makes every tie resolve to p0.
    assign w_last = WIN_P1;
`endif

    sram_arb_select u_select (
        .i_req0   (p0_req),
        .i_req1   (p1_req),
        .i_last   (w_last),
        .o_winner (w_winner),
        .o_valid  (w_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_we          <= 1'b0;
            p0_done       <= 1'b0;
            p1_done       <= 1'b0;
            p0_rdata      <= '0;
            p1_rdata      <= '0;
            mem_wrEn      <= 1'b0;
            mem_rdEn      <= 1'b0;
            mem_address   <= '0;
            mem_writeData <= '0;
            busy          <= 1'b0;
            grant_id      <= 1'b0;
        end else begin
            mem_wrEn <= 1'b0;
            mem_rdEn <= 1'b0;
            p0_done  <= 1'b0;
            p1_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (mem_ready && w_valid) begin
                        r_we          <= (w_winner == WIN_P1) ? p1_we : p0_we;
                        mem_address   <= (w_winner == WIN_P1) ? p1_addr : p0_addr;
                        mem_writeData <= (w_winner == WIN_P1) ? p1_wdata : p0_wdata;
                        mem_wrEn      <= (w_winner == WIN_P1) ? p1_we : p0_we;
                        mem_rdEn      <= (w_winner == WIN_P1) ? ~p1_we : ~p0_we;
                        grant_id      <= w_winner;
                        busy          <= 1'b1;
                        r_state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_WAIT_START;
                end
                ST_WAIT_START: begin
                    if (!mem_ready) begin
                        r_state <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    // Controller back to ready means the access has finished.
                    if (mem_ready) begin
                        if (!r_we) begin
                            if (grant_id == WIN_P1) begin
                                p1_rdata <= mem_readData;
                            end else begin
                                p0_rdata <= mem_readData;
                            end
                        end
                        p0_done       <= (grant_id == WIN_P0);
                        p1_done       <= (grant_id == WIN_P1);
                        mem_address   <= '0;
                        mem_writeData <= '0;
                        r_state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter with a small behavioural SRAM controller.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p1_req, p0_we, p1_we;
    logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
    logic        p0_done, p1_done;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_wrEn, mem_rdEn;
    logic [31:0] mem_address, mem_writeData, mem_readData;
    logic        mem_ready;
    logic        busy, grant_id;

    int errors = 0;
    int checks = 0;

    // Controller model knobs
    int   busy_cycles = 2;
    logic hold_low = 1'b0;
    logic r_ready;
    int   r_cnt;
    logic [31:0] mem [0:1023];

    always #5 clk = ~clk;

    sram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .p0_req        (p0_req),
        .p1_req        (p1_req),
        .p0_we         (p0_we),
        .p1_we         (p1_we),
        .p0_addr       (p0_addr),
        .p1_addr       (p1_addr),
        .p0_wdata      (p0_wdata),
        .p1_wdata      (p1_wdata),
        .p0_done       (p0_done),
        .p1_done       (p1_done),
        .p0_rdata      (p0_rdata),
        .p1_rdata      (p1_rdata),
        .mem_wrEn      (mem_wrEn),
        .mem_rdEn      (mem_rdEn),
        .mem_address   (mem_address),
        .mem_writeData (mem_writeData),
        .mem_readData  (mem_readData),
        .mem_ready     (mem_ready),
        .busy          (busy),
        .grant_id      (grant_id)
    );

    assign mem_ready = r_ready & ~hold_low;

    // Strobe drops ready next cycle; ready returns after busy_cycles more cycles.
    always @(posedge clk) begin
        if (rst) begin
            r_ready          <= 1'b1;
            r_cnt            <= 0;
            mem_readData     <= 32'h0;
            mem[10'h100]     <= 32'hDEADBEEF;
        end else if (mem_rdEn || mem_wrEn) begin
            r_ready <= 1'b0;
            r_cnt   <= busy_cycles;
            if (mem_wrEn) mem[mem_address[11:2]] <= mem_writeData;
            else          mem_readData <= mem[mem_address[11:2]];
        end else if (!r_ready) begin
            if (r_cnt == 0) r_ready <= 1'b1;
            else            r_cnt   <= r_cnt - 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request on one port, run to its done pulse, then check strobes and results.
    task automatic txn(input logic port, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp0,
                       input logic [31:0] exp1, input int exp_lat, input string tag);
        int          lat = 0;
        int          n_rd = 0;
        int          n_wr = 0;
        logic        seen = 1'b0;
        logic [31:0] s_addr = 32'h0;
        logic [31:0] s_wdata = 32'h0;
        if (port) begin
            p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata;
        end else begin
            p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wdata;
        end
        while (!seen && lat < 60) begin
            @(negedge clk);
            lat++;
            if (mem_rdEn) n_rd++;
            if (mem_wrEn) n_wr++;
            if (mem_rdEn || mem_wrEn) begin
                s_addr  = mem_address;
                s_wdata = mem_writeData;
            end
            seen = port ? p1_done : p0_done;
        end
        chk({tag, "_done"}, 32'(seen), 32'd1);
        if (exp_lat != 0) chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        if (port) p1_req = 1'b0; else p0_req = 1'b0;
        chk({tag, "_rd_pulses"}, 32'(n_rd), we ? 32'd0 : 32'd1);
        chk({tag, "_wr_pulses"}, 32'(n_wr), we ? 32'd1 : 32'd0);
        chk({tag, "_strobe_addr"}, s_addr, addr);
        if (we) chk({tag, "_strobe_wdata"}, s_wdata, wdata);
        chk({tag, "_grant_id"}, 32'(grant_id), 32'(port));
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, 32'({p1_done, p0_done}), 32'd0);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_idle_addr"}, mem_address, 32'h0);
        chk({tag, "_p0_rdata"}, p0_rdata, exp0);
        chk({tag, "_p1_rdata"}, p1_rdata, exp1);
    endtask

    logic exp_order [0:3];
    logic got_order [0:3];

    initial begin
        int n;
        int cyc;
        logic seen;
        rst = 1'b1;
        p0_req = 1'b0; p1_req = 1'b0; p0_we = 1'b0; p1_we = 1'b0;
        p0_addr = 32'h0; p1_addr = 32'h0; p0_wdata = 32'h0; p1_wdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_strobes", 32'({mem_wrEn, mem_rdEn}), 32'd0);
        chk("rst_done", 32'({p1_done, p0_done}), 32'd0);
        chk("rst_p0_rdata", p0_rdata, 32'h0);
        chk("rst_addr", mem_address, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // p0 read: ISSUE, WAIT_START, 3x WAIT_DONE (ready low for 2+1 cycles), DONE -> 6
        txn(1'b0, 1'b0, 32'h400, 32'h0, 32'hDEADBEEF, 32'h0, 6, "p0_rd400");
        txn(1'b1, 1'b1, 32'h404, 32'h12345678, 32'hDEADBEEF, 32'h0, 6, "p1_wr404");
        txn(1'b1, 1'b0, 32'h404, 32'h0, 32'hDEADBEEF, 32'h12345678, 6, "p1_rd404");

        // Simultaneous held requests; last grant so far was p1.
`ifdef ARB_ROUND_ROBIN_EN
        exp_order[0] = 1'b0; exp_order[1] = 1'b1; exp_order[2] = 1'b0; exp_order[3] = 1'b1;
`else
        exp_order[0] = 1'b0; exp_order[1] = 1'b0; exp_order[2] = 1'b0; exp_order[3] = 1'b0;
`endif
        p0_we = 1'b0; p0_addr = 32'h400; p1_we = 1'b0; p1_addr = 32'h404;
        p0_req = 1'b1; p1_req = 1'b1;
        n = 0; cyc = 0;
        while (n < 4 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (p0_done || p1_done) begin
                got_order[n] = p1_done;
                n++;
            end
        end
        chk("tie_grant_count", 32'(n), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < n) chk($sformatf("tie_grant_%0d", i), 32'(got_order[i]), 32'(exp_order[i]));
        end
        p0_req = 1'b0;
        seen = 1'b0; cyc = 0;
        while (!seen && cyc < 60) begin
            @(negedge clk);
            cyc++;
            seen = p0_done | p1_done;
        end
        chk("tie_after_drop_p1", 32'({p1_done, p0_done}), 32'b10);
        p1_req = 1'b0;
        @(negedge clk);
        chk("tie_after_drop_idle", 32'(busy), 32'd0);

        // Reset while in WAIT_DONE aborts with no done pulse.
        busy_cycles = 6;
        p0_we = 1'b0; p0_addr = 32'h400; p0_req = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(p0_done), 32'd0);
        chk("abort_rdata_cleared", p0_rdata, 32'h0);
        chk("abort_strobe", 32'({mem_wrEn, mem_rdEn}), 32'd0);
        rst = 1'b0;
        busy_cycles = 2;
        txn(1'b0, 1'b0, 32'h400, 32'h0, 32'hDEADBEEF, 32'h0, 6, "after_abort");

        // mem_ready low at request: arbiter must wait in IDLE.
        hold_low = 1'b1;
        p1_we = 1'b0; p1_addr = 32'h404; p1_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("notready_busy_%0d", i), 32'(busy), 32'd0);
            chk($sformatf("notready_strobe_%0d", i), 32'({mem_wrEn, mem_rdEn}), 32'd0);
        end
        hold_low = 1'b0;
        @(negedge clk);
        chk("ready_issue_rdEn", 32'(mem_rdEn), 32'd1);
        chk("ready_issue_busy", 32'(busy), 32'd1);
        chk("ready_issue_addr", mem_address, 32'h404);
        seen = 1'b0; cyc = 0;
        while (!seen && cyc < 60) begin
            @(negedge clk);
            cyc++;
            seen = p1_done;
        end
        chk("ready_done", 32'(seen), 32'd1);
        p1_req = 1'b0;
        @(negedge clk);
        chk("ready_p1_rdata", p1_rdata, 32'h12345678);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
